// File: rtl/z80_im2_int_ctrl.sv
// z80_im2_int_ctrl: Z80 mode-2 interrupt responder with RETI snooping.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   irq_req, irq_mask     per-source requests (rising edge) and enables
//   vec_base              vector base byte, upper bits merged with source index
//   m1_n, iorq_n, mreq_n, rd_n, di   CPU bus strobes and snooped data
//   int_n                 interrupt request to CPU, active low
//   vec_do, vec_oe        vector byte and its drive enable during the ack cycle
//   in_service            in-service bits, bit 0 highest priority
module z80_im2_int_ctrl #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq_req,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic [7:0]       vec_base,
    input  logic             m1_n,
    input  logic             iorq_n,
    input  logic             mreq_n,
    input  logic             rd_n,
    input  logic [7:0]       di,
    output logic             int_n,
    output logic [7:0]       vec_do,
    output logic             vec_oe,
    output logic [N_SRC-1:0] in_service
);
    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
    state_t state, state_nx;
    logic [N_SRC-1:0] req_q, pending, eligible, top_isr, ack_set;
    logic [IDX_W-1:0] sel, sel_nx, first_elig;
    logic             blocked, int_n_nx, ack_done;
    logic             fetch, fetch_q, fetch_end, saw_ed, reti;
    logic [7:0]       op_q;
    logic             unused_vec_bits;
    assign unused_vec_bits = ^vec_base[IDX_W:0];
    // An in-service level blocks itself and everything below it.
    always_comb begin
        blocked    = 1'b0;
        eligible   = '0;
        first_elig = '0;
        top_isr    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            blocked     = blocked | in_service[i];
            eligible[i] = pending[i] & irq_mask[i] & ~blocked;
        end
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) first_elig = IDX_W'(i);
            if (in_service[i]) top_isr = N_SRC'(1) << i;
        end
    end
    // An ack seen in REQ always completes, even if eligibility vanished meanwhile.
    always_comb begin
        state_nx = state;
        int_n_nx = int_n;
        sel_nx   = sel;
        ack_done = 1'b0;
        case (state)
            IDLE: begin
                int_n_nx = ~|eligible;
                state_nx = |eligible ? REQ : IDLE;
            end
            REQ: begin
                if (!m1_n && !iorq_n) begin
                    state_nx = ACK;
                    sel_nx   = first_elig;
                    int_n_nx = 1'b0;
                end else begin
                    int_n_nx = ~|eligible;
                    state_nx = |eligible ? REQ : IDLE;
                end
            end
            ACK: begin
                if (iorq_n) begin
                    state_nx = IDLE;
                    int_n_nx = 1'b1;
                    ack_done = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    assign ack_set   = ack_done ? N_SRC'(1) << sel : '0;
    assign fetch     = ~m1_n & ~mreq_n & ~rd_n;
    assign fetch_end = fetch_q & ~fetch;
    assign reti      = fetch_end & saw_ed & (op_q == 8'h4D);
    assign vec_oe    = (state == ACK) & ~m1_n & ~iorq_n;
    assign vec_do    = (state == ACK) ? {vec_base[7:IDX_W+1], sel, 1'b0} : 8'h00;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            int_n      <= 1'b1;
            sel        <= '0;
            req_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            fetch_q    <= 1'b0;
            op_q       <= 8'h00;
            saw_ed     <= 1'b0;
        end else begin
            state      <= state_nx;
            int_n      <= int_n_nx;
            sel        <= sel_nx;
            req_q      <= irq_req;
            pending    <= (pending & ~ack_set) | (irq_req & ~req_q);
            in_service <= (in_service & ~(reti ? top_isr : '0)) | ack_set;
            fetch_q    <= fetch;
            if (fetch) op_q <= di;
            if (fetch_end) saw_ed <= (op_q == 8'hED);
        end
    end
endmodule

// File: tb/tb_z80_im2_int_ctrl.sv
// tb_z80_im2_int_ctrl: directed self-checking bench for z80_im2_int_ctrl.
module tb_z80_im2_int_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] irq_req = '0;
    logic [3:0] irq_mask = 4'hF;
    logic [7:0] vec_base = 8'hE6;
    logic       m1_n = 1'b1, iorq_n = 1'b1, mreq_n = 1'b1, rd_n = 1'b1;
    logic [7:0] di = 8'h00;
    logic       int_n, vec_oe;
    logic [7:0] vec_do;
    logic [3:0] in_service;
    int n_chk = 0;
    int n_fail = 0;

    z80_im2_int_ctrl #(.N_SRC(4), .IDX_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .irq_req(irq_req), .irq_mask(irq_mask),
        .vec_base(vec_base), .m1_n(m1_n), .iorq_n(iorq_n), .mreq_n(mreq_n),
        .rd_n(rd_n), .di(di), .int_n(int_n), .vec_do(vec_do), .vec_oe(vec_oe),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int idx);
        irq_req[idx] = 1'b1;
        tick();
        irq_req[idx] = 1'b0;
    endtask

    task automatic wait_int(input logic exp, input string tag);
        int n = 0;
        while (int_n !== exp && n < 8) begin
            tick();
            n++;
        end
        chk(tag, int_n, exp);
    endtask

    task automatic ack(input logic [7:0] exp_vec, input logic [3:0] exp_isr, input string tag);
        m1_n = 1'b0;
        iorq_n = 1'b0;
        tick();
        chk({tag, "_oe"}, vec_oe, 1'b1);
        chk({tag, "_vec"}, vec_do, exp_vec);
        m1_n = 1'b1;
        iorq_n = 1'b1;
        #1;
        chk({tag, "_oe_off"}, vec_oe, 1'b0);
        tick();
        chk({tag, "_int_hi"}, int_n, 1'b1);
        chk({tag, "_isr"}, in_service, exp_isr);
    endtask

    task automatic fetch(input logic [7:0] op);
        m1_n = 1'b0;
        mreq_n = 1'b0;
        rd_n = 1'b0;
        di = op;
        tick();
        rd_n = 1'b1;
        mreq_n = 1'b1;
        m1_n = 1'b1;
        tick();
    endtask

    initial begin
        // 1 reset
        tick();
        tick();
        chk("rst_int", int_n, 1'b1);
        chk("rst_oe", vec_oe, 1'b0);
        chk("rst_vec", vec_do, 8'h00);
        chk("rst_isr", in_service, 4'h0);
        reset_n = 1'b1;
        repeat (4) tick();
        chk("idle_int", int_n, 1'b1);

        // 2 basic ack
        pulse(1);
        wait_int(1'b0, "basic_int_lo");
        ack(8'hE2, 4'b0010, "basic");
        fetch(8'hED);
        fetch(8'h4D);
        chk("basic_reti", in_service, 4'b0000);

        // 3 priority
        irq_req = 4'b1001;
        tick();
        irq_req = 4'b0000;
        wait_int(1'b0, "prio_int_lo");
        ack(8'hE0, 4'b0001, "prio0");
        fetch(8'hED);
        fetch(8'h4D);
        wait_int(1'b0, "prio3_int_lo");
        ack(8'hE6, 4'b1000, "prio3");
        fetch(8'hED);
        fetch(8'h4D);
        chk("prio_reti", in_service, 4'b0000);

        // 4 nesting
        pulse(2);
        wait_int(1'b0, "nest2_int_lo");
        ack(8'hE4, 4'b0100, "nest2");
        pulse(3);
        repeat (4) tick();
        chk("nest_blocked", int_n, 1'b1);
        pulse(0);
        wait_int(1'b0, "nest0_int_lo");
        ack(8'hE0, 4'b0101, "nest0");
        fetch(8'hED);
        fetch(8'h4D);
        chk("nest_reti1", in_service, 4'b0100);
        repeat (3) tick();
        chk("nest_still_blk", int_n, 1'b1);
        fetch(8'hED);
        fetch(8'h4D);
        wait_int(1'b0, "nest3_int_lo");
        ack(8'hE6, 4'b1000, "nest3");
        fetch(8'hED);
        fetch(8'h4D);
        chk("nest_reti2", in_service, 4'b0000);

        // 5 RETI decode
        pulse(1);
        wait_int(1'b0, "dec_int_lo");
        ack(8'hE2, 4'b0010, "dec");
        fetch(8'hED);
        fetch(8'h00);
        fetch(8'h4D);
        chk("dec_ed00_4d", in_service, 4'b0010);
        fetch(8'hED);
        fetch(8'hED);
        fetch(8'h4D);
        chk("dec_eded_4d", in_service, 4'b0000);
        pulse(2);
        wait_int(1'b0, "dec2_int_lo");
        di = 8'hED;
        ack(8'hE4, 4'b0100, "dec_iorq");
        fetch(8'h4D);
        chk("dec_iorq_ignored", in_service, 4'b0100);
        fetch(8'hED);
        fetch(8'h4D);
        chk("dec_final", in_service, 4'b0000);
        fetch(8'hED);
        fetch(8'h4D);
        chk("dec_reti_empty", in_service, 4'b0000);

        // 6 mask and reset
        irq_mask = 4'b1011;
        pulse(2);
        repeat (4) tick();
        chk("mask_hold", int_n, 1'b1);
        irq_mask = 4'hF;
        wait_int(1'b0, "mask_int_lo");
        irq_mask = 4'b1011;
        tick();
        chk("mask_drop", int_n, 1'b1);
        irq_mask = 4'hF;
        wait_int(1'b0, "mask_int_lo2");
        m1_n = 1'b0;
        iorq_n = 1'b0;
        tick();
        chk("rstack_oe", vec_oe, 1'b1);
        chk("rstack_vec", vec_do, 8'hE4);
        reset_n = 1'b0;
        #1;
        chk("rstack_oe_off", vec_oe, 1'b0);
        chk("rstack_int", int_n, 1'b1);
        chk("rstack_isr", in_service, 4'b0000);
        m1_n = 1'b1;
        iorq_n = 1'b1;
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("rstack_no_pend", int_n, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
